// File: rtl/data_memory_ctrl_if.sv
// Request/response bundle between the memory-task decode and the data memory.
// The master drives the access request; the slave returns the load data and status.
interface data_memory_ctrl_if;
    logic        req;
    logic        read_enable;
    logic        write_enable;
    logic [63:0] mem_address;
    logic [63:0] mem_data;
    logic [63:0] valM;
    logic        dmem_error;
    logic        busy;
    logic        done;

    modport master (
        output req, read_enable, write_enable, mem_address, mem_data,
        input  valM, dmem_error, busy, done
    );

    modport slave (
        input  req, read_enable, write_enable, mem_address, mem_data,
        output valM, dmem_error, busy, done
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// Y86-64 memory-stage data memory: 8-byte little-endian loads/stores into a
// byte array, with range checking and a fixed parameterised access latency.
module data_memory_ctrl #(
    parameter int MEM_BYTES = 1024,
    parameter int LATENCY   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    data_memory_ctrl_if.slave  bus
);
    localparam int AW = $clog2(MEM_BYTES);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_ACCESS = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [63:0]   addr_q, data_q, valm_q;
    logic          re_q, we_q, err_q, busy_q;
    logic [3:0]    cnt_q;
    logic [7:0]    mem_q [MEM_BYTES];

    logic [AW-1:0] base;
    logic          addr_bad;
    logic          req_bad;
    logic          req_nop;
    logic [63:0]   rd_word;

    // Signed address: bit 63 set means negative, otherwise compare unsigned.
    assign base     = addr_q[AW-1:0];
    assign addr_bad = addr_q[63] || (addr_q > 64'(MEM_BYTES - 8));
    assign req_bad  = addr_bad || (re_q && we_q);
    assign req_nop  = !re_q && !we_q;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rd_lane
            assign rd_word[8*gi +: 8] = mem_q[base + AW'(gi)];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.req) state_d = S_CHECK;
            S_CHECK: begin
                if (req_bad || req_nop) state_d = S_DONE;
                else if (LATENCY == 0)  state_d = S_ACCESS;
                else                    state_d = S_WAIT;
            end
            S_WAIT:   if (cnt_q <= 4'd1) state_d = S_ACCESS;
            S_ACCESS: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            valm_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (bus.req) begin
                        addr_q <= bus.mem_address;
                        data_q <= bus.mem_data;
                        re_q   <= bus.read_enable;
                        we_q   <= bus.write_enable;
                        busy_q <= 1'b1;
                        err_q  <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (req_bad) err_q <= 1'b1;
                    else         cnt_q <= 4'(LATENCY);
                end
                S_WAIT:   cnt_q <= cnt_q - 4'd1;
                S_ACCESS: if (re_q) valm_q <= rd_word;
                S_DONE:   busy_q <= 1'b0;
                default:  ;
            endcase
        end
    end

    // Array is never reset; an async reset leaves ACCESS before the next edge.
    always_ff @(posedge clk) begin
        if (rst_n && state_q == S_ACCESS && we_q) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[base + AW'(i)] <= data_q[8*i +: 8];
            end
        end
    end

    assign bus.valM       = valm_q;
    assign bus.dmem_error = err_q;
    assign bus.busy       = busy_q;
    assign bus.done       = (state_q == S_DONE);
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: one LATENCY=2 instance and one
// LATENCY=0 instance sharing clock and reset.
module tb_data_memory_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_memory_ctrl_if bus_a ();
    data_memory_ctrl_if bus_b ();

    data_memory_ctrl #(.MEM_BYTES(1024), .LATENCY(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    data_memory_ctrl #(.MEM_BYTES(1024), .LATENCY(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic drive(input bit sel, input logic rq, input logic r, input logic w,
                         input logic [63:0] a, input logic [63:0] d);
        if (!sel) begin
            bus_a.req = rq; bus_a.read_enable = r; bus_a.write_enable = w;
            bus_a.mem_address = a; bus_a.mem_data = d;
        end else begin
            bus_b.req = rq; bus_b.read_enable = r; bus_b.write_enable = w;
            bus_b.mem_address = a; bus_b.mem_data = d;
        end
    endtask

    // Accept at edge 0, scramble inputs, return the cycle in which done is seen (-1 on timeout).
    task automatic issue(input bit sel, input logic r, input logic w,
                         input logic [63:0] a, input logic [63:0] d, output int cyc);
        @(negedge clk);
        drive(sel, 1'b1, r, w, a, d);
        @(posedge clk);
        #1 drive(sel, 1'b0, ~r, ~w, 64'hDEAD_BEEF_0000_0000, ~d);
        cyc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((sel ? bus_b.done : bus_a.done) === 1'b1) begin
                cyc = k;
                break;
            end
        end
        $display("[TB] txn dut=%0d r=%0b w=%0b addr=%h data=%h done_cycle=%0d valM=%h err=%0b",
                 sel, r, w, a, d, cyc, sel ? bus_b.valM : bus_a.valM,
                 sel ? bus_b.dmem_error : bus_a.dmem_error);
    endtask

    task automatic test_reset();
        int cyc;
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (bus_a.valM !== 64'd0) begin n_fail++; $display("FAIL reset_valM: got %h expected 0", bus_a.valM); end
        n_tests++; if (bus_a.dmem_error !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus_a.dmem_error); end
        n_tests++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus_a.busy); end
        n_tests++; if (bus_a.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus_a.done); end
        n_tests++; if (bus_b.valM !== 64'd0) begin n_fail++; $display("FAIL reset_valM_b: got %h expected 0", bus_b.valM); end
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_write_read();
        int cyc;
        issue(1'b0, 1'b0, 1'b1, 64'h10, 64'h0123456789ABCDEF, cyc);
        n_tests++; if (cyc !== 4) begin n_fail++; $display("FAIL wr_done_cycle: got %0d expected 4", cyc); end
        n_tests++; if (bus_a.busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy_in_done: got %b expected 1", bus_a.busy); end
        n_tests++; if (bus_a.dmem_error !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b expected 0", bus_a.dmem_error); end
        @(negedge clk);
        n_tests++; if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) begin n_fail++; $display("FAIL wr_after_done: busy=%b done=%b expected 0 0", bus_a.busy, bus_a.done); end
        n_tests++; if (u_dut_a.mem_q[16] !== 8'hEF) begin n_fail++; $display("FAIL wr_byte10: got %h expected ef", u_dut_a.mem_q[16]); end
        n_tests++; if (u_dut_a.mem_q[23] !== 8'h01) begin n_fail++; $display("FAIL wr_byte17: got %h expected 01", u_dut_a.mem_q[23]); end
        issue(1'b0, 1'b1, 1'b0, 64'h10, 64'h0, cyc);
        n_tests++; if (cyc !== 4) begin n_fail++; $display("FAIL rd_done_cycle: got %0d expected 4", cyc); end
        n_tests++; if (bus_a.valM !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL rd_valM: got %h expected 0123456789abcdef", bus_a.valM); end
        n_tests++; if (bus_a.dmem_error !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b expected 0", bus_a.dmem_error); end
    endtask

    task automatic test_boundary();
        int cyc;
        issue(1'b0, 1'b0, 1'b1, 64'd1016, 64'h1122334455667788, cyc);
        issue(1'b0, 1'b1, 1'b0, 64'd1016, 64'h0, cyc);
        n_tests++; if (bus_a.valM !== 64'h1122334455667788 || bus_a.dmem_error !== 1'b0) begin n_fail++; $display("FAIL bnd_top_read: valM=%h err=%b expected 1122334455667788 0", bus_a.valM, bus_a.dmem_error); end
        issue(1'b0, 1'b1, 1'b0, 64'd1017, 64'h0, cyc);
        n_tests++; if (bus_a.dmem_error !== 1'b1) begin n_fail++; $display("FAIL bnd_1017_err: got %b expected 1", bus_a.dmem_error); end
        n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL bnd_1017_cycle: got %0d expected 1", cyc); end
        n_tests++; if (bus_a.valM !== 64'h1122334455667788) begin n_fail++; $display("FAIL bnd_1017_valM_hold: got %h expected 1122334455667788", bus_a.valM); end
        issue(1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, cyc);
        n_tests++; if (bus_a.dmem_error !== 1'b1 || cyc !== 1) begin n_fail++; $display("FAIL bnd_neg8: err=%b cycle=%0d expected 1 1", bus_a.dmem_error, cyc); end
        // Nop right after an error must clear the error and leave valM alone.
        issue(1'b0, 1'b0, 1'b0, 64'h30, 64'h0, cyc);
        n_tests++; if (cyc !== 1 || bus_a.dmem_error !== 1'b0) begin n_fail++; $display("FAIL nop: cycle=%0d err=%b expected 1 0", cyc, bus_a.dmem_error); end
        n_tests++; if (bus_a.valM !== 64'h1122334455667788) begin n_fail++; $display("FAIL nop_valM_hold: got %h expected 1122334455667788", bus_a.valM); end
    endtask

    task automatic test_both_enables();
        int cyc;
        issue(1'b0, 1'b0, 1'b1, 64'h0, 64'h0F0E0D0C0B0A0908, cyc);
        issue(1'b0, 1'b1, 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, cyc);
        n_tests++; if (bus_a.dmem_error !== 1'b1 || cyc !== 1) begin n_fail++; $display("FAIL both_en: err=%b cycle=%0d expected 1 1", bus_a.dmem_error, cyc); end
        issue(1'b0, 1'b1, 1'b0, 64'h0, 64'h0, cyc);
        n_tests++; if (bus_a.valM !== 64'h0F0E0D0C0B0A0908) begin n_fail++; $display("FAIL both_en_mem: got %h expected 0f0e0d0c0b0a0908", bus_a.valM); end
    endtask

    task automatic test_reset_mid_write();
        int cyc;
        issue(1'b0, 1'b0, 1'b1, 64'h20, 64'h5555_5555_5555_5555, cyc);
        issue(1'b0, 1'b1, 1'b0, 64'h20, 64'h0, cyc);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 64'h20, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk);
        #1 bus_a.req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++; if (bus_a.busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b expected 1", bus_a.busy); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus_a.valM !== 64'd0 || bus_a.dmem_error !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) begin n_fail++; $display("FAIL mid_reset_outputs: valM=%h err=%b busy=%b done=%b expected all 0", bus_a.valM, bus_a.dmem_error, bus_a.busy, bus_a.done); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        issue(1'b0, 1'b1, 1'b0, 64'h20, 64'h0, cyc);
        n_tests++; if (bus_a.valM !== 64'h5555_5555_5555_5555) begin n_fail++; $display("FAIL mid_reset_mem: got %h expected 5555555555555555", bus_a.valM); end
    endtask

    task automatic test_busy_req();
        int cyc;
        int n_done;
        issue(1'b0, 1'b0, 1'b1, 64'h40, 64'h7777_6666_5555_4444, cyc);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 64'h10, 64'h0);
        @(posedge clk);
        #1 bus_a.req = 1'b0;
        n_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus_a.done === 1'b1) n_done++;
            if (k <= 1 || k == 4) drive(1'b0, 1'b1, 1'b0, 1'b1, 64'h40, 64'hCAFE);
            else                  drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        end
        n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL busy_req_done_count: got %0d expected 1", n_done); end
        n_tests++; if (bus_a.valM !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL busy_req_valM: got %h expected 0123456789abcdef", bus_a.valM); end
        issue(1'b0, 1'b1, 1'b0, 64'h40, 64'h0, cyc);
        n_tests++; if (bus_a.valM !== 64'h7777_6666_5555_4444) begin n_fail++; $display("FAIL busy_req_not_queued: got %h expected 7777666655554444", bus_a.valM); end
    endtask

    task automatic test_latency0();
        int cyc;
        issue(1'b1, 1'b0, 1'b1, 64'h10, 64'h1716151413121110, cyc);
        n_tests++; if (cyc !== 2) begin n_fail++; $display("FAIL lat0_wr_cycle: got %0d expected 2", cyc); end
        issue(1'b1, 1'b0, 1'b1, 64'h18, 64'h1F1E1D1C1B1A1918, cyc);
        issue(1'b1, 1'b1, 1'b0, 64'h13, 64'h0, cyc);
        n_tests++; if (cyc !== 2) begin n_fail++; $display("FAIL lat0_rd_cycle: got %0d expected 2", cyc); end
        n_tests++; if (bus_b.valM !== 64'h1A19181716151413) begin n_fail++; $display("FAIL lat0_unaligned: got %h expected 1a19181716151413", bus_b.valM); end
        n_tests++; if (bus_b.dmem_error !== 1'b0) begin n_fail++; $display("FAIL lat0_err: got %b expected 0", bus_b.dmem_error); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_boundary();
        test_both_enables();
        test_reset_mid_write();
        test_busy_req();
        test_latency0();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
